// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: state encoding and opcode constants.
// Optional stall watchdog is enabled by defining FETCH_WDOG_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        F1    = 2'd1,
        F2    = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    // Opcode high nibble marking a two-byte (opcode + immediate) instruction
    localparam logic [3:0] LONG_OPC = 4'hC;
    // Byte presented to the IR as a bubble
    localparam logic [7:0] NOP_OPC  = 8'h00;

endpackage

// File: rtl/fetch_stall_wdog.sv
// Stall watchdog: counts consecutive stall cycles and raises a sticky error
// once the run length reaches STALL_MAX. Instantiated only when FETCH_WDOG_EN is defined.
module fetch_stall_wdog #(
    parameter int unsigned STALL_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic stall_err
);

    logic [3:0] r_cnt;
    logic       r_err;
    logic [3:0] w_cnt_next;

    // Saturating run-length count of consecutive stall cycles
    always_comb begin
        w_cnt_next = '0;
        if (stall) begin
            w_cnt_next = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
        end
    end

    // Counter register and sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (stall && (w_cnt_next == 4'(STALL_MAX))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign stall_err = r_err;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: splits the instruction byte stream into one-byte and
// two-byte instructions and drives the IR next-value, second-fetch flag and
// flush request. Outputs are Mealy; the IR captures them at the next edge.
// Define FETCH_WDOG_EN to add the stall watchdog and the stall_err port.
module fetch_ctrl #(
    parameter logic [3:0]  LONG_OPC  = fetch_pkg::LONG_OPC,
    parameter logic [7:0]  NOP_OPC   = fetch_pkg::NOP_OPC
`ifdef FETCH_WDOG_EN
    ,
    parameter int unsigned STALL_MAX = 15
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    input  logic       stall,
    input  logic       branch_taken,
    output logic [7:0] ir_next,
    output logic       sf1_next,
    output logic       flush_ir,
    output logic       pc_inc,
    output logic       imm_valid
`ifdef FETCH_WDOG_EN
    ,
    output logic       stall_err
`endif
);

    import fetch_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [7:0]   r_ir_hold;
    logic         r_sf1_hold;

    // State register and hold registers that let a stalled IR reload itself
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ir_hold  <= NOP_OPC;
            r_sf1_hold <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (branch_taken) begin
                r_ir_hold  <= NOP_OPC;
                r_sf1_hold <= 1'b0;
            end else if (!stall) begin
                r_ir_hold  <= ir_next;
                r_sf1_hold <= sf1_next;
            end
        end
    end

    // Next state and outputs; priority is branch, then stall, then memory ready
    always_comb begin
        w_state_next = r_state;
        ir_next      = NOP_OPC;
        sf1_next     = 1'b0;
        flush_ir     = 1'b0;
        pc_inc       = 1'b0;
        imm_valid    = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_state_next = F1;
            end

            FLUSH: begin
                // One settling bubble for the redirected PC; stall has no effect here
                if (branch_taken) begin
                    flush_ir     = 1'b1;
                    w_state_next = FLUSH;
                end else begin
                    w_state_next = F1;
                end
            end

            F1, F2: begin
                if (branch_taken) begin
                    flush_ir     = 1'b1;
                    w_state_next = FLUSH;
                end else if (stall) begin
                    ir_next  = r_ir_hold;
                    sf1_next = r_sf1_hold;
                end else if (!mem_ready) begin
                    // Bubble; in F2 the immediate is still owed, so the flag stays raised
                    sf1_next = (r_state == F2);
                end else if (r_state == F2) begin
                    ir_next      = mem_data;
                    imm_valid    = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = F1;
                end else begin
                    ir_next = mem_data;
                    pc_inc  = 1'b1;
                    if (mem_data[7:4] == LONG_OPC) begin
                        sf1_next     = 1'b1;
                        w_state_next = F2;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef FETCH_WDOG_EN
    fetch_stall_wdog #(
        .STALL_MAX (STALL_MAX)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .stall_err (stall_err)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed sequences with literal
// expectations, then randomized traffic compared cycle by cycle against a
// behavioural model of the fetch rules. Honours FETCH_WDOG_EN.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       stall;
    logic       branch_taken;
    logic [7:0] ir_next;
    logic       sf1_next;
    logic       flush_ir;
    logic       pc_inc;
    logic       imm_valid;
`ifdef FETCH_WDOG_EN
    logic       stall_err;
`endif

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Model: what the front end owes and what the IR would reload on a stall
    bit         m_started;
    bit         m_flushing;
    bit         m_owed;
    logic [7:0] m_held;
    bit         m_held_sf1;
    int         m_run;
    bit         m_err;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .ir_next      (ir_next),
        .sf1_next     (sf1_next),
        .flush_ir     (flush_ir),
        .pc_inc       (pc_inc),
        .imm_valid    (imm_valid)
`ifdef FETCH_WDOG_EN
        ,
        .stall_err    (stall_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_flushing = 1'b0;
        m_owed     = 1'b0;
        m_held     = 8'h00;
        m_held_sf1 = 1'b0;
        m_run      = 0;
        m_err      = 1'b0;
    endtask

    // Compute expected outputs for the current cycle, compare, then advance the model
    task automatic check_cycle();
        logic [7:0] e_ir;
        logic e_sf1, e_fl, e_pc, e_imm;
        e_ir = 8'h00; e_sf1 = 1'b0; e_fl = 1'b0; e_pc = 1'b0; e_imm = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (branch_taken) begin
            e_fl       = 1'b1;
            m_owed     = 1'b0;
            m_flushing = 1'b1;
            m_held     = 8'h00;
            m_held_sf1 = 1'b0;
        end else if (m_flushing) begin
            m_flushing = 1'b0;
            if (!stall) begin
                m_held     = 8'h00;
                m_held_sf1 = 1'b0;
            end
        end else if (stall) begin
            e_ir  = m_held;
            e_sf1 = m_held_sf1;
        end else begin
            if (!mem_ready) begin
                e_sf1 = m_owed;
            end else if (m_owed) begin
                e_ir   = mem_data;
                e_imm  = 1'b1;
                e_pc   = 1'b1;
                m_owed = 1'b0;
            end else begin
                e_ir   = mem_data;
                e_pc   = 1'b1;
                e_sf1  = (mem_data[7:4] == 4'hC);
                m_owed = e_sf1;
            end
            m_held     = e_ir;
            m_held_sf1 = e_sf1;
        end
        chk("ir_next",   {24'h0, ir_next}, {24'h0, e_ir});
        chk("sf1_next",  {31'h0, sf1_next},  {31'h0, e_sf1});
        chk("flush_ir",  {31'h0, flush_ir},  {31'h0, e_fl});
        chk("pc_inc",    {31'h0, pc_inc},    {31'h0, e_pc});
        chk("imm_valid", {31'h0, imm_valid}, {31'h0, e_imm});
`ifdef FETCH_WDOG_EN
        chk("stall_err", {31'h0, stall_err}, {31'h0, m_err});
`endif
        if (rst) begin
            m_run = stall ? ((m_run < 15) ? m_run + 1 : 15) : 0;
            if (m_run == 15) m_err = 1'b1;
        end
    endtask

    // One clock: drive inputs just after the edge, check in mid-cycle
    task automatic cycle(input logic r, input logic rdy, input logic [7:0] d,
                         input logic st, input logic br);
        @(posedge clk);
        #1;
        if (!m_started) begin
            st = 1'b0;
            br = 1'b0;
        end
        rst          = r;
        mem_ready    = rdy;
        mem_data     = d;
        stall        = st;
        branch_taken = br;
        #3;
        check_cycle();
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b0; mem_ready = 1'b0; mem_data = 8'h00; stall = 1'b0; branch_taken = 1'b0;
        model_reset();

        // Reset: outputs silent whatever the inputs
        repeat (3) cycle(1'b0, 1'b1, 8'hC5, 1'b1, 1'b1);
        chk("rst_ir", {24'h0, ir_next}, 32'h00);
        chk("rst_pc", {31'h0, pc_inc}, 32'h0);

        // IDLE for one cycle, then two one-byte instructions
        cycle(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        chk("idle_ir", {24'h0, ir_next}, 32'h00);
        chk("idle_pc", {31'h0, pc_inc}, 32'h0);
        cycle(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        chk("s1_ir", {24'h0, ir_next}, 32'h12);
        chk("s1_pc", {31'h0, pc_inc}, 32'h1);
        chk("s1_sf1", {31'h0, sf1_next}, 32'h0);
        cycle(1'b1, 1'b1, 8'h34, 1'b0, 1'b0);
        chk("s2_ir", {24'h0, ir_next}, 32'h34);
        chk("s2_pc", {31'h0, pc_inc}, 32'h1);

        // Two-byte instruction
        cycle(1'b1, 1'b1, 8'hC5, 1'b0, 1'b0);
        chk("long_ir", {24'h0, ir_next}, 32'hC5);
        chk("long_sf1", {31'h0, sf1_next}, 32'h1);
        cycle(1'b1, 1'b1, 8'h7F, 1'b0, 1'b0);
        chk("imm_ir", {24'h0, ir_next}, 32'h7F);
        chk("imm_v", {31'h0, imm_valid}, 32'h1);
        chk("imm_sf1", {31'h0, sf1_next}, 32'h0);
        cycle(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        chk("post_imm_v", {31'h0, imm_valid}, 32'h0);
        chk("post_imm_ir", {24'h0, ir_next}, 32'h12);

        // Stall holds the issued byte and consumes nothing
        repeat (3) begin
            cycle(1'b1, 1'b1, 8'h56, 1'b1, 1'b0);
            chk("stall_ir", {24'h0, ir_next}, 32'h12);
            chk("stall_pc", {31'h0, pc_inc}, 32'h0);
        end
        cycle(1'b1, 1'b1, 8'h56, 1'b0, 1'b0);
        chk("resume_ir", {24'h0, ir_next}, 32'h56);
        chk("resume_pc", {31'h0, pc_inc}, 32'h1);

        // Branch while the immediate is owed
        cycle(1'b1, 1'b1, 8'hC5, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hAB, 1'b0, 1'b1);
        chk("br_flush", {31'h0, flush_ir}, 32'h1);
        chk("br_ir", {24'h0, ir_next}, 32'h00);
        chk("br_imm", {31'h0, imm_valid}, 32'h0);
        cycle(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("fl_ir", {24'h0, ir_next}, 32'h00);
        chk("fl_flush", {31'h0, flush_ir}, 32'h0);
        chk("fl_pc", {31'h0, pc_inc}, 32'h0);
        cycle(1'b1, 1'b1, 8'h21, 1'b0, 1'b0);
        chk("after_fl_ir", {24'h0, ir_next}, 32'h21);
        chk("after_fl_imm", {31'h0, imm_valid}, 32'h0);

        // Memory bubbles, then branch with stall, then stall ignored in FLUSH
        repeat (2) begin
            cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
            chk("bub_ir", {24'h0, ir_next}, 32'h00);
            chk("bub_pc", {31'h0, pc_inc}, 32'h0);
        end
        cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        chk("brst_flush", {31'h0, flush_ir}, 32'h1);
        chk("brst_pc", {31'h0, pc_inc}, 32'h0);
        cycle(1'b1, 1'b1, 8'h88, 1'b1, 1'b0);
        chk("flst_ir", {24'h0, ir_next}, 32'h00);
        cycle(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
        chk("flst_next_ir", {24'h0, ir_next}, 32'h88);

        // Memory bubble while the immediate is owed
        cycle(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        chk("f2bub_imm", {31'h0, imm_valid}, 32'h0);
        chk("f2bub_pc", {31'h0, pc_inc}, 32'h0);
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("f2late_ir", {24'h0, ir_next}, 32'h3C);
        chk("f2late_imm", {31'h0, imm_valid}, 32'h1);

        // Asynchronous reset discards a half-fetched instruction
        cycle(1'b1, 1'b1, 8'hC5, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
        chk("arst_ir", {24'h0, ir_next}, 32'h00);
        chk("arst_sf1", {31'h0, sf1_next}, 32'h0);
        cycle(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        chk("arst_opc_ir", {24'h0, ir_next}, 32'h12);
        chk("arst_opc_imm", {31'h0, imm_valid}, 32'h0);

`ifdef FETCH_WDOG_EN
        // Watchdog trips after 15 stall cycles and stays set until reset
        repeat (15) cycle(1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
        chk("wd_set", {31'h0, stall_err}, 32'h1);
        repeat (3) cycle(1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
        chk("wd_sticky", {31'h0, stall_err}, 32'h1);
        repeat (3) cycle(1'b1, 1'b1, 8'h42, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 8'h42, 1'b1, 1'b0);
        chk("wd_rst", {31'h0, stall_err}, 32'h0);
        chk("wd_rst_ir", {24'h0, ir_next}, 32'h00);
        // 14 stalls must not trip it
        cycle(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        repeat (14) cycle(1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        chk("wd_14", {31'h0, stall_err}, 32'h0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) d[7:4] = 4'hC;
            cycle(($urandom_range(0, 149) != 0),
                  ($urandom_range(0, 3) != 0),
                  d,
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
